// File: rtl/lcd_register_file_if.sv
// rtl/lcd_register_file_if.sv - write/read bus of the LCD register file
//
// Purpose: groups the register file's single write port and single read port
// so the sequencer and the output driver can share one bus bundle.
// Signals:
//   writeAddr  - entry written on the next rising edge (sequencer drives)
//   dataIn     - value written to writeAddr (sequencer drives)
//   addrToRead - entry shown on dataOut (driver logic drives)
//   dataOut    - contents of entry addrToRead, combinational (register file drives)
// Modports: master = user side, slave = register file side.

interface lcd_register_file_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] writeAddr;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [ADDR_WIDTH-1:0] addrToRead;
  logic [DATA_WIDTH-1:0] dataOut;

  modport master (
    output writeAddr,
    output dataIn,
    output addrToRead,
    input  dataOut
  );

  modport slave (
    input  writeAddr,
    input  dataIn,
    input  addrToRead,
    output dataOut
  );
endinterface

// File: rtl/lcd_register_file.sv
// rtl/lcd_register_file.sv - 32x8 LCD controller register file
//
// Purpose: holds LCD controller state bytes. One synchronous write port that
// writes on every non-reset edge (no write enable) and one asynchronous read
// port with zero-cycle latency.
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - synchronous, active-high; clears every entry to zero
//   bus   - lcd_register_file_if.slave: writeAddr/dataIn in, addrToRead in,
//           dataOut out

module lcd_register_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  lcd_register_file_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Every edge writes exactly one entry; callers preserve contents by parking
  // writeAddr or writing back the current value.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    mem_d[bus.writeAddr] = bus.dataIn;
  end

  // Reset wins over the write presented at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // No write-through bypass: a same-address read shows the old value until
  // the edge.
  assign bus.dataOut = mem_q[bus.addrToRead];

endmodule

// File: tb/tb_lcd_register_file.sv
// tb/tb_lcd_register_file.sv - directed self-checking bench for lcd_register_file

module tb_lcd_register_file;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  lcd_register_file_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

  lcd_register_file #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one write before the next rising edge; returns 1 time unit after it.
  task automatic write_cycle(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.writeAddr = a;
    bus.dataIn    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic read_at(input logic [4:0] a, output logic [7:0] d);
    bus.addrToRead = a;
    #1;
    d = bus.dataOut;
  endtask

  // Single reset edge with writes parked on entry 0 writing zero afterwards.
  task automatic pulse_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.writeAddr = 5'd0;
    bus.dataIn    = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    pulse_reset();
    for (int i = 0; i < 32; i++) begin
      read_at(5'(i), v);
      checks++;
      if (v !== 8'h00) begin
        failures++;
        $display("FAIL reset_state addr=%0d got=%h exp=%h", i, v, 8'h00);
      end
    end
  endtask

  task automatic test_reset_clear();
    logic [7:0] v;
    for (int i = 0; i < 32; i++) write_cycle(5'(i), 8'hA5);
    read_at(5'd17, v);
    checks++;
    if (v !== 8'hA5) begin
      failures++;
      $display("FAIL fill_a5 addr=17 got=%h exp=%h", v, 8'hA5);
    end
    pulse_reset();
    for (int i = 0; i < 32; i++) begin
      read_at(5'(i), v);
      checks++;
      if (v !== 8'h00) begin
        failures++;
        $display("FAIL reset_clear addr=%0d got=%h exp=%h", i, v, 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    for (int i = 0; i < 32; i++) write_cycle(5'(i), 8'hF0);
    write_cycle(5'd0, 8'hF0);
    for (int i = 0; i < 32; i++) begin
      read_at(5'(i), v);
      checks++;
      if (v !== 8'hF0) begin
        failures++;
        $display("FAIL seq_sweep addr=%0d got=%h exp=%h", i, v, 8'hF0);
      end
    end
  endtask

  task automatic test_distinct();
    logic [7:0] v;
    logic [7:0] exp;
    for (int i = 0; i < 32; i++) write_cycle(5'(i), 8'(i * 7));
    for (int i = 0; i < 32; i++) begin
      exp = 8'(i * 7);
      read_at(5'(i), v);
      checks++;
      if (v !== exp) begin
        failures++;
        $display("FAIL distinct addr=%0d got=%h exp=%h", i, v, exp);
      end
    end
    read_at(5'd5, v);
    checks++;
    if (v !== 8'h23) begin
      failures++;
      $display("FAIL distinct_addr5 got=%h exp=%h", v, 8'h23);
    end
    read_at(5'd31, v);
    checks++;
    if (v !== 8'hD9) begin
      failures++;
      $display("FAIL distinct_addr31 got=%h exp=%h", v, 8'hD9);
    end
  endtask

  // One write must leave every other entry untouched.
  task automatic test_isolation();
    logic [7:0] v;
    logic [7:0] exp;
    write_cycle(5'd10, 8'h5A);
    for (int i = 0; i < 32; i++) begin
      exp = (i == 10) ? 8'h5A : 8'(i * 7);
      read_at(5'(i), v);
      checks++;
      if (v !== exp) begin
        failures++;
        $display("FAIL isolation addr=%0d got=%h exp=%h", i, v, exp);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [7:0] v;
    write_cycle(5'd3, 8'h11);
    @(negedge clk);
    bus.addrToRead = 5'd3;
    bus.writeAddr  = 5'd3;
    bus.dataIn     = 8'h80;
    #1;
    v = bus.dataOut;
    checks++;
    if (v !== 8'h11) begin
      failures++;
      $display("FAIL rdw_before got=%h exp=%h", v, 8'h11);
    end
    @(posedge clk);
    #1;
    v = bus.dataOut;
    checks++;
    if (v !== 8'h80) begin
      failures++;
      $display("FAIL rdw_after got=%h exp=%h", v, 8'h80);
    end
  endtask

  task automatic test_reset_priority();
    logic [7:0] v;
    write_cycle(5'd7, 8'h3C);
    @(negedge clk);
    reset         = 1'b1;
    bus.writeAddr = 5'd7;
    bus.dataIn    = 8'hFF;
    @(posedge clk);
    #1;
    read_at(5'd7, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL reset_priority_addr7 got=%h exp=%h", v, 8'h00);
    end
    read_at(5'd3, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL reset_priority_addr3 got=%h exp=%h", v, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    read_at(5'd7, v);
    checks++;
    if (v !== 8'hFF) begin
      failures++;
      $display("FAIL reset_release_write got=%h exp=%h", v, 8'hFF);
    end
  endtask

  task automatic test_comb_read();
    logic [7:0] v;
    write_cycle(5'd0, 8'h01);
    write_cycle(5'd1, 8'h02);
    bus.addrToRead = 5'd0;
    #1;
    v = bus.dataOut;
    checks++;
    if (v !== 8'h01) begin
      failures++;
      $display("FAIL comb_read_addr0 got=%h exp=%h", v, 8'h01);
    end
    bus.addrToRead = 5'd1;
    #1;
    v = bus.dataOut;
    checks++;
    if (v !== 8'h02) begin
      failures++;
      $display("FAIL comb_read_addr1 got=%h exp=%h", v, 8'h02);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.writeAddr  = 5'd0;
    bus.dataIn     = 8'h00;
    bus.addrToRead = 5'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_reset_clear();
    test_back_to_back();
    test_distinct();
    test_isolation();
    test_read_during_write();
    test_reset_priority();
    test_comb_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
